// File: rtl/silu_lut_input_requant.sv
// Requantises PARALLELISM signed fixed-point lanes to the SiLU LUT input format
// (round half up, saturate) through a 2-stage valid/ready pipeline.
// Optional macro SILU_REQUANT_SAT_CNT_EN enables the per-lane saturation flags and sat_count.
module silu_lut_input_requant #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_FRAC_WIDTH  = 8,
    parameter int OUT_WIDTH      = 6,
    parameter int OUT_FRAC_WIDTH = 3,
    parameter int PARALLELISM    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PARALLELISM*IN_WIDTH-1:0]  data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [PARALLELISM*OUT_WIDTH-1:0] data_out_0,
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready,
    output logic [CNT_WIDTH-1:0]             sat_count
);

    localparam int SHIFT     = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int RND_WIDTH = IN_WIDTH + 1 - SHIFT;
    localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [RND_WIDTH-1:0] OUT_MAX = RND_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RND_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    logic en1;
    logic en2;
    logic v1_reg;
    logic v2_reg;
    logic [RND_WIDTH-1:0]             rnd_next [PARALLELISM];
    logic [RND_WIDTH-1:0]             rnd_reg  [PARALLELISM];
    logic [OUT_WIDTH-1:0]             clamp_next [PARALLELISM];
    logic [PARALLELISM*OUT_WIDTH-1:0] out_next;
    logic [PARALLELISM*OUT_WIDTH-1:0] out_reg;

    assign en2             = !v2_reg || data_out_0_ready;
    assign en1             = !v1_reg || en2;
    assign data_in_0_ready = en1 && !rst;

    generate
        for (genvar gi = 0; gi < PARALLELISM; gi++) begin : lane
            logic [IN_WIDTH:0] ext;
            logic [IN_WIDTH:0] sum;
            logic              unused_low;

            // One extra sign bit keeps the rounding add from wrapping at the positive limit.
            assign ext = {data_in_0[gi*IN_WIDTH+IN_WIDTH-1], data_in_0[gi*IN_WIDTH +: IN_WIDTH]};
            assign sum = ext + HALF;
            // Dropping the low SHIFT bits of a two's complement value is an arithmetic shift.
            assign rnd_next[gi] = sum[IN_WIDTH:SHIFT];
            assign unused_low   = ^sum[SHIFT-1:0];

            always_comb begin
                clamp_next[gi] = rnd_reg[gi][OUT_WIDTH-1:0];
                if ($signed(rnd_reg[gi]) > OUT_MAX) begin
                    clamp_next[gi] = OUT_MAX[OUT_WIDTH-1:0];
                end else if ($signed(rnd_reg[gi]) < OUT_MIN) begin
                    clamp_next[gi] = OUT_MIN[OUT_WIDTH-1:0];
                end
            end

            assign out_next[gi*OUT_WIDTH +: OUT_WIDTH] = clamp_next[gi];
        end
    endgenerate

    // Stage-1 data needs no reset: v1_reg alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (en1 && data_in_0_valid) begin
            for (int i = 0; i < PARALLELISM; i++) begin
                rnd_reg[i] <= rnd_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg  <= 1'b0;
            v2_reg  <= 1'b0;
            out_reg <= '0;
        end else begin
            if (en1) begin
                v1_reg <= data_in_0_valid;
            end
            if (en2) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    out_reg <= out_next;
                end
            end
        end
    end

    assign data_out_0       = out_reg;
    assign data_out_0_valid = v2_reg;

`ifdef SILU_REQUANT_SAT_CNT_EN
    localparam int NSAT_WIDTH = $clog2(PARALLELISM + 1);
    localparam int SUM_WIDTH  = CNT_WIDTH + NSAT_WIDTH;
    localparam logic [SUM_WIDTH-1:0] CNT_MAX = SUM_WIDTH'({CNT_WIDTH{1'b1}});

    logic [PARALLELISM-1:0] sat_flag;
    logic [NSAT_WIDTH-1:0]  nsat;
    logic [SUM_WIDTH-1:0]   cnt_sum;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [CNT_WIDTH-1:0]   cnt_next;

    generate
        for (genvar gi = 0; gi < PARALLELISM; gi++) begin : lane_sat
            // Exactly OUT_MIN is representable, so it is not a saturation event.
            assign sat_flag[gi] = ($signed(rnd_reg[gi]) > OUT_MAX) ||
                                  ($signed(rnd_reg[gi]) < OUT_MIN);
        end
    endgenerate

    always_comb begin
        nsat = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            nsat = nsat + NSAT_WIDTH'(sat_flag[i]);
        end
    end

    assign cnt_sum = SUM_WIDTH'(cnt_reg) + SUM_WIDTH'(nsat);

    always_comb begin
        cnt_next = cnt_reg;
        if (en2 && v1_reg) begin
            cnt_next = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign sat_count = cnt_reg;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_silu_lut_input_requant.sv
// Bench for silu_lut_input_requant: directed cases plus randomized traffic checked
// every cycle against a real-arithmetic model and a queue scoreboard.
module tb_silu_lut_input_requant;

    typedef struct {
        logic [23:0] data;
        int          nsat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, in_ready4;
    logic [23:0] dout, dout4;
    logic        out_valid, out_valid4;
    logic [15:0] sat16;
    logic [3:0]  sat4;

    beat_t q[$];
    int tests = 0;
    int fails = 0;
    int delivered_sat = 0;
    int ready_mode = 0;
    int tog = 0;

    always #5 clk = ~clk;

    silu_lut_input_requant dut (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(in_ready),
        .data_out_0(dout), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready),
        .sat_count(sat16)
    );

    silu_lut_input_requant #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(in_ready4),
        .data_out_0(dout4), .data_out_0_valid(out_valid4), .data_out_0_ready(out_ready),
        .sat_count(sat4)
    );

    // Value as a real number, rounded to the nearest 1/8 (ties up), then clamped to [-4.0, 3.875].
    function automatic logic [5:0] model_lane(input logic [15:0] x, output int sat);
        real v;
        int  r;
        v = real'($signed(x)) / 256.0;
        r = int'($floor(v * 8.0 + 0.5));
        sat = 0;
        if (r > 31) begin
            r = 31;
            sat = 1;
        end else if (r < -32) begin
            r = -32;
            sat = 1;
        end
        return r[5:0];
    endfunction

    function automatic beat_t model_beat(input logic [63:0] b);
        beat_t t;
        int s;
        t.nsat = 0;
        t.data = '0;
        for (int l = 0; l < 4; l++) begin
            t.data[l*6 +: 6] = model_lane(b[l*16 +: 16], s);
            t.nsat += s;
        end
        return t;
    endfunction

    function automatic int cap(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard; handshakes seen here complete at the next edge.
    always @(negedge clk) begin : cmp
        int    occ;
        int    tot;
        logic  exp_rdy;
        occ = q.size();
        if (out_valid) begin
            if (occ == 0) begin
                tests++;
                fails++;
                $display("FAIL ghost: output valid with no beat outstanding, data %0h", dout);
            end else begin
                check("data", dout, q[0].data);
                check("data4", dout4, q[0].data);
            end
        end
        check("valid4", out_valid4, out_valid);
        tot = delivered_sat + ((out_valid && occ > 0) ? q[0].nsat : 0);
`ifdef SILU_REQUANT_SAT_CNT_EN
        check("sat_count", sat16, cap(tot, 65535));
        check("sat_count4", sat4, cap(tot, 15));
`else
        check("sat_count", sat16, 0);
        check("sat_count4", sat4, 0);
`endif
        exp_rdy = !rst && !(occ == 2 && !out_ready);
        check("in_ready", in_ready, exp_rdy);
        check("in_ready4", in_ready4, exp_rdy);
        if (rst) begin
            q.delete();
            delivered_sat = 0;
        end else begin
            if (out_valid && out_ready && occ > 0) begin
                delivered_sat += q[0].nsat;
                void'(q.pop_front());
            end
            if (din_valid && in_ready) q.push_back(model_beat(din));
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            out_ready = (tog % 3 == 0);
            tog++;
        end else if (ready_mode == 2) begin
            out_ready = ($urandom % 2) == 1;
        end
    end

    // Called and returns at posedge+1.
    task automatic send(input logic [63:0] b);
        int n;
        n = 0;
        din = b;
        din_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready stayed %0b, expected 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [63:0] b, input logic [23:0] exp);
        ready_mode = 0;
        out_ready = 1'b1;
        send(b);
        @(negedge clk);
        check({name, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        check({name, "_lat2_valid"}, out_valid, 1);
        check({name, "_data"}, dout, exp);
        @(negedge clk);
        check({name, "_one_cycle"}, out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_lane();
        int v;
        case ($urandom % 4)
            0: v = int'($urandom % 65536) - 32768;
            1: v = (($urandom % 2) == 1 ? 1008 : -1040) + int'($urandom_range(0, 32)) - 16;
            2: v = (int'($urandom_range(0, 63)) - 32) * 32 + 16 + int'($urandom % 3) - 1;
            default: v = int'($urandom % 2048) - 1024;
        endcase
        return 16'(v);
    endfunction

    initial begin : main
        int s;
        logic [5:0] m;
        logic [63:0] b;

        // Model pinned against hand-computed values.
        m = model_lane(16'h0110, s);
        check("model_1p0625", {m, 8'(s)}, {6'd9, 8'd0});
        m = model_lane(16'hFFF8, s);
        check("model_m0p03125", {m, 8'(s)}, {6'd0, 8'd0});
        m = model_lane(16'h03F8, s);
        check("model_round_to_32", {m, 8'(s)}, {6'b011111, 8'd1});
        m = model_lane(16'hFC00, s);
        check("model_exact_m32", {m, 8'(s)}, {6'b100000, 8'd0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", dout, 0);
        check("reset_sat", sat16, 0);
        @(posedge clk);
        #1;

        directed("t1", 64'h0100_0100_0100_0100, 24'h208208);
        directed("t2", {16'hFFF8, 16'h0008, 16'hFEF0, 16'h0110}, 24'h000E09);
        directed("t3", {16'hFC00, 16'hF800, 16'h7FFF, 16'h03F8}, 24'h8207DF);
`ifdef SILU_REQUANT_SAT_CNT_EN
        check("t3_sat_total", sat16, 3);
`else
        check("t3_sat_total", sat16, 0);
`endif

        // Backpressure with a 1,0,0 ready pattern.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            for (int l = 0; l < 4; l++) b[l*16 +: 16] = 16'((i * 4 + l) * 32);
            send(b);
        end
        drain();
        ready_mode = 0;

        // Reset with both stages full.
        out_ready = 1'b0;
        send(64'h0200_0200_0200_0200);
        send({16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after_rst", out_valid, 0);
        check("t5_sat_after_rst", sat16, 0);
        @(posedge clk);
        #1;
        directed("t5_post", 64'h0100_0100_0100_0100, 24'h208208);

        // 20 saturation events: the 4-bit counter must stick at all-ones.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send({16'hF000, 16'h0400, 16'h8000, 16'h7FFF});
        drain();
`ifdef SILU_REQUANT_SAT_CNT_EN
        check("t6_sat4_sticky", sat4, 4'hF);
        check("t6_sat16", sat16, 20);
`else
        check("t6_sat4_sticky", sat4, 0);
        check("t6_sat16", sat16, 0);
`endif

        // Randomized traffic with random backpressure and idle gaps.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < 4; l++) b[l*16 +: 16] = rand_lane();
            send(b);
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
